traffic_phase_timer: RTL and testbench

Upstream pacing stage for the cyclic traffic lamp. It holds each lamp phase (red, green, yellow) for a programmable number of ticks, then issues a one-clock `step` pulse that advances the lamp. It also services a pedestrian request that cuts green short once a minimum green time has elapsed. Its `phase` and `light` outputs use the same state numbering and lamp encoding as the lamp stage, so the two can be cross-checked.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 26 ++
 rtl/traffic_phase_timer.sv | 124 ++++++++++++
 tb/tb_traffic_phase_timer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase numbering and lamp encoding for the traffic lamp and its pacing timer.
package traffic_pkg;

  localparam int unsigned PHASE_W = 2;
  localparam int unsigned LIGHT_W = 3;

  localparam logic [PHASE_W-1:0] PH_RED    = 2'd0;
  localparam logic [PHASE_W-1:0] PH_GREEN  = 2'd1;
  localparam logic [PHASE_W-1:0] PH_YELLOW = 2'd2;

  localparam logic [LIGHT_W-1:0] RED    = 3'b100;
  localparam logic [LIGHT_W-1:0] GREEN  = 3'b010;
  localparam logic [LIGHT_W-1:0] YELLOW = 3'b001;

  // Unknown phase codes show red so the lamp never displays a permissive aspect.
  function automatic logic [LIGHT_W-1:0] phase_to_light(input logic [PHASE_W-1:0] ph);
    logic [LIGHT_W-1:0] lt;
    case (ph)
      PH_GREEN:  lt = GREEN;
      PH_YELLOW: lt = YELLOW;
      default:   lt = RED;
    endcase
    return lt;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE enabled cycles; the count freezes while en is low.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/traffic_phase_timer.sv
// Lamp phase pacing: per-phase dwell counting, pedestrian green cut and lamp decode.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned RED_TICKS    = 8,
  parameter int unsigned GREEN_TICKS  = 6,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned MIN_GREEN    = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               ped_req,
  output logic               ped_ack,
  output logic               step,
  output logic [PHASE_W-1:0] phase,
  output logic [LIGHT_W-1:0] light,
  output logic [CNT_W-1:0]   remaining
);

  localparam logic [CNT_W-1:0] RED_LD    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);

  logic               tick;
  logic               ped_q;
  logic               latch_q;
  logic               ped_rise;
  logic               last_tick;
  logic               green_cut;
  logic [PHASE_W-1:0] phase_d;
  logic [CNT_W-1:0]   rem_d;
  logic               step_d;
  logic               ack_d;
  logic               latch_d;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  assign ped_rise  = ped_req & ~ped_q;
  assign last_tick = (remaining == '0);
  // Elapsed green ticks including the current one; remaining never exceeds GREEN_TICKS-1 here.
  assign green_cut = latch_q && ((GREEN_TICKS - 32'(remaining)) >= MIN_GREEN);

  // Next-state, dwell counter and request latch.
  always_comb begin
    phase_d = phase;
    rem_d   = remaining;
    step_d  = 1'b0;
    ack_d   = 1'b0;
    latch_d = latch_q | ped_rise;
    case (phase)
      PH_RED: begin
        if (tick) begin
          if (last_tick) begin
            phase_d = PH_GREEN;
            rem_d   = GREEN_LD;
            step_d  = 1'b1;
          end else begin
            rem_d = remaining - CNT_W'(1);
          end
        end
      end
      PH_GREEN: begin
        if (tick) begin
          if (last_tick || green_cut) begin
            phase_d = PH_YELLOW;
            rem_d   = YELLOW_LD;
            step_d  = 1'b1;
          end else begin
            rem_d = remaining - CNT_W'(1);
          end
        end
      end
      PH_YELLOW: begin
        if (tick) begin
          if (last_tick) begin
            phase_d = PH_RED;
            rem_d   = RED_LD;
            step_d  = 1'b1;
            ack_d   = latch_q;
            // Serving the request also swallows an edge arriving in the same cycle.
            if (latch_q) latch_d = 1'b0;
          end else begin
            rem_d = remaining - CNT_W'(1);
          end
        end
      end
      default: begin
        phase_d = PH_RED;
        rem_d   = RED_LD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= PH_RED;
      remaining <= RED_LD;
      step      <= 1'b0;
      ped_ack   <= 1'b0;
      latch_q   <= 1'b0;
      ped_q     <= 1'b0;
    end else begin
      phase     <= phase_d;
      remaining <= rem_d;
      step      <= step_d;
      ped_ack   <= ack_d;
      latch_q   <= latch_d;
      ped_q     <= ped_req;
    end
  end

  assign light = phase_to_light(phase);

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: tick-level behavioural model plus directed scenarios with literal timing.
module tb_traffic_phase_timer;

  localparam int P  = 4;
  localparam int RT = 8;
  localparam int GT = 6;
  localparam int YT = 2;
  localparam int MG = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          ped_req = 1'b0;
  logic          ped_ack;
  logic          step;
  logic [1:0]    phase;
  logic [2:0]    light;
  logic [CW-1:0] remaining;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  traffic_phase_timer #(
    .PRESCALE(P), .RED_TICKS(RT), .GREEN_TICKS(GT), .YELLOW_TICKS(YT),
    .MIN_GREEN(MG), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ped_req(ped_req), .ped_ack(ped_ack),
    .step(step), .phase(phase), .light(light), .remaining(remaining)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Model: phase durations in ticks; a phase ends when its elapsed tick count hits its duration.
  int       dur[3] = '{RT, GT, YT};
  logic [2:0] lt[3] = '{3'b100, 3'b010, 3'b001};
  int m_phase, m_el, m_pc;
  bit m_latch, m_prev, m_step, m_ack;

  always @(posedge clk or posedge rst) begin : model
    bit tick, rise, adv;
    if (rst) begin
      m_phase = 0; m_el = 0; m_pc = 0;
      m_latch = 0; m_prev = 0; m_step = 0; m_ack = 0;
    end else begin
      tick = en && (m_pc == P - 1);
      rise = ped_req && !m_prev;
      m_step = 0;
      m_ack  = 0;
      if (tick) begin
        m_el++;
        adv = (m_el == dur[m_phase]) || (m_phase == 1 && m_latch && m_el >= MG);
        if (adv) begin
          m_step  = 1;
          m_phase = (m_phase + 1) % 3;
          m_el    = 0;
          m_ack   = (m_phase == 0) && m_latch;
        end
      end
      if (m_ack)     m_latch = 0;
      else if (rise) m_latch = 1;
      m_prev = ped_req;
      if (en) m_pc = (m_pc + 1) % P;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("step",      int'(step),      int'(m_step));
      chk("ped_ack",   int'(ped_ack),   int'(m_ack));
      chk("phase",     int'(phase),     m_phase);
      chk("light",     int'(light),     int'(lt[m_phase]));
      chk("remaining", int'(remaining), dur[m_phase] - 1 - m_el);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Waits for the next step pulse and pins its cycle, new lamp and ack literally.
  task automatic expect_step(input string name, input int exp_cyc, input int exp_light, input int exp_ack);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (step) begin
        chk({name, "_cyc"},   cyc,            exp_cyc);
        chk({name, "_light"}, int'(light),    exp_light);
        chk({name, "_ack"},   int'(ped_ack),  exp_ack);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: no step within 100 clk, expected at cyc %0d", name, exp_cyc);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_phase", int'(phase), 0);
    chk("rst_light", int'(light), 4);
    chk("rst_rem",   int'(remaining), 7);
    chk("rst_step",  int'(step), 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // Free-running cycle
    expect_step("red_end", 32, 3'b010, 0);
    chk("green_start_rem", int'(remaining), 5);
    expect_step("green_end", 56, 3'b001, 0);
    expect_step("yellow_end", 64, 3'b100, 0);
    chk("red_start_rem", int'(remaining), 7);

    // Enable freeze for 10 clk at remaining=4
    wait_cyc(76);
    chk("freeze_entry_rem", int'(remaining), 4);
    en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("freeze_rem", int'(remaining), 4);
    end
    en = 1'b1;
    expect_step("stretched_red", 106, 3'b010, 0);

    // Request 9 clk into green: cut after 3 ticks
    wait_cyc(115);
    ped_req = 1'b1;
    expect_step("cut_green_late", 118, 3'b001, 0);
    ped_req = 1'b0;
    expect_step("ack_red_1", 126, 3'b100, 1);
    @(negedge clk);
    chk("ack_one_clk", int'(ped_ack), 0);
    expect_step("plain_green_1", 158, 3'b010, 0);
    expect_step("full_green_1", 182, 3'b001, 0);
    expect_step("no_ack_red_1", 190, 3'b100, 0);

    // Request 1 clk into green: green held for MIN_GREEN ticks
    expect_step("green_2", 222, 3'b010, 0);
    wait_cyc(223);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    expect_step("cut_green_min", 230, 3'b001, 0);
    expect_step("ack_red_2", 238, 3'b100, 1);

    // Request during red, repeat pulses before the ack, and an edge on the ack cycle
    wait_cyc(243);
    ped_req = 1'b1;
    wait_cyc(245);
    ped_req = 1'b0;
    expect_step("green_after_red_req", 270, 3'b010, 0);
    expect_step("cut_green_red_req", 278, 3'b001, 0);
    wait_cyc(280);
    ped_req = 1'b1;
    wait_cyc(281);
    ped_req = 1'b0;
    wait_cyc(285);
    ped_req = 1'b1;
    expect_step("ack_red_3", 286, 3'b100, 1);
    ped_req = 1'b0;
    expect_step("green_3", 318, 3'b010, 0);
    expect_step("full_green_3", 342, 3'b001, 0);

    // Asynchronous reset mid-yellow
    wait_cyc(345);
    #2 rst = 1'b1;
    #1;
    chk("arst_light", int'(light), 4);
    chk("arst_phase", int'(phase), 0);
    chk("arst_rem",   int'(remaining), 7);
    chk("arst_step",  int'(step), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_step("post_reset_red", 32, 3'b010, 0);
    expect_step("post_reset_green", 56, 3'b001, 0);

    @(negedge clk);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
